// File: rtl/ldr_writeback_queue_if.sv
// ldr_writeback_queue_if
// Bundles the issue, response, hazard-query and register-file write-port
// signals of the load writeback queue.
//   master : the environment side. It drives issue/flush/response/source regs.
//   slave  : the queue side. It drives stall_full, the write port, pending_cnt
//            and resp_orphan, plus ldr_hazard when LDR_HAZARD_EN is defined.
// Optional macro: LDR_HAZARD_EN (adds ldr_hazard).
interface ldr_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int OPC_W  = 7
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic [OPC_W-1:0]  issue_opcode;
    logic [REG_AW-1:0] issue_rd;
    logic              sel_stall;
    logic              flush;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              stall_full;
    logic              w_en_ldr;
    logic [REG_AW-1:0] w_addr_ldr;
    logic [DATA_W-1:0] w_data_ldr;
    logic [CNT_W-1:0]  pending_cnt;
    logic              resp_orphan;
`ifdef LDR_HAZARD_EN
    logic              ldr_hazard;
`endif

    modport master (
        output issue_valid, issue_opcode, issue_rd, sel_stall, flush,
        output mem_rvalid, mem_rdata, src_a, src_b,
        input  stall_full, w_en_ldr, w_addr_ldr, w_data_ldr, pending_cnt,
`ifdef LDR_HAZARD_EN
        input  ldr_hazard,
`endif
        input  resp_orphan
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_rd, sel_stall, flush,
        input  mem_rvalid, mem_rdata, src_a, src_b,
        output stall_full, w_en_ldr, w_addr_ldr, w_data_ldr, pending_cnt,
`ifdef LDR_HAZARD_EN
        output ldr_hazard,
`endif
        output resp_orphan
    );
endinterface

// File: rtl/ldr_writeback_queue.sv
// ldr_writeback_queue
// Tracks up to DEPTH outstanding loads in issue order. Each in-order memory
// response is paired with the destination register at the head of the queue.
// The register-file load write port is driven one cycle after the response.
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : ldr_writeback_queue_if.slave.
//              Inputs:  issue_valid/opcode/rd, sel_stall, flush,
//                       mem_rvalid/rdata, src_a/src_b.
//              Outputs: stall_full, w_en_ldr/w_addr_ldr/w_data_ldr,
//                       pending_cnt, resp_orphan, and ldr_hazard when
//                       the macro is defined.
// Optional macro: LDR_HAZARD_EN. It adds the combinational ldr_hazard
// comparator against src_a/src_b.
module ldr_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int OPC_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    ldr_writeback_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_AW-1:0] rd_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              wb_vld_p1;
    logic [REG_AW-1:0] wb_addr_p1;
    logic [DATA_W-1:0] wb_data_p1;
    logic              orphan_p1;

    logic is_load;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // ---- stage p0: decode and queue handshake ----
    assign is_load = (bus.issue_opcode[6:4] == 3'b110) ||
                     (bus.issue_opcode[6:3] == 4'b1000);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A full queue refuses a push even when a pop happens in the same cycle.
    // This keeps stall_full purely a function of the registered count.
    assign push    = bus.issue_valid && is_load && !bus.sel_stall && !full && !bus.flush;
    assign pop     = bus.mem_rvalid && !empty && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is not reset. The head/tail/count fields decide which
    // entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) rd_mem[tail] <= bus.issue_rd;
    end

    // ---- stage p1: register-file write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld_p1  <= 1'b0;
            wb_addr_p1 <= '0;
            wb_data_p1 <= '0;
            orphan_p1  <= 1'b0;
        end else begin
            wb_vld_p1 <= pop;
            orphan_p1 <= bus.mem_rvalid && empty;
            // Address and data hold their last values between writes.
            if (pop) begin
                wb_addr_p1 <= rd_mem[head];
                wb_data_p1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.stall_full  = full;
    assign bus.pending_cnt = count;
    assign bus.w_en_ldr    = wb_vld_p1;
    assign bus.w_addr_ldr  = wb_addr_p1;
    assign bus.w_data_ldr  = wb_data_p1;
    assign bus.resp_orphan = orphan_p1;

`ifdef LDR_HAZARD_EN
    logic             hazard;
    logic [PTR_W-1:0] rel;

    // An entry is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        hazard = wb_vld_p1 && ((wb_addr_p1 == bus.src_a) || (wb_addr_p1 == bus.src_b));
        rel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - head;
            if (({1'b0, rel} < count) &&
                ((rd_mem[i] == bus.src_a) || (rd_mem[i] == bus.src_b)))
                hazard = 1'b1;
        end
    end

    assign bus.ldr_hazard = hazard;
`endif

endmodule

// File: doc/ldr_writeback_queue.md
Name: ldr_writeback_queue

Overview:
- Parametrised successor to the single-instruction load-writeback controller stage.
- Tracks up to DEPTH outstanding loads in issue order and pairs each in-order memory response with its destination register.
- Drives the register-file load write port one cycle after the response.
- Sits between the memory-access stage and the register file; raises a stall when no more loads can be accepted.

Parameters:
- DEPTH, 4, maximum outstanding loads (power of two, >=2).
- DATA_W, 32, load data width.
- REG_AW, 4, register address width.
- OPC_W, 7, decoded opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  decoded instruction presented this cycle.
- issue_opcode  in  OPC_W  decoded opcode.
- issue_rd  in  REG_AW  load destination register.
- sel_stall  in  1  upstream stall; suppresses issue acceptance.
- flush  in  1  discard all pending loads.
- mem_rvalid  in  1  in-order load response valid.
- mem_rdata  in  DATA_W  load response data.
- src_a  in  REG_AW  consumer source register A (hazard check).
- src_b  in  REG_AW  consumer source register B (hazard check).
- stall_full  out  1  queue full; upstream must hold load issue.
- w_en_ldr  out  1  register-file load write enable.
- w_addr_ldr  out  REG_AW  register-file write address.
- w_data_ldr  out  DATA_W  register-file write data.
- pending_cnt  out  clog2(DEPTH)+1  outstanding load count.
- resp_orphan  out  1  pulse: response arrived with queue empty.

Behaviour:
- Reset (rst=1 at a clk edge): queue empty, pointers=0, pending_cnt=0, w_en_ldr=0, w_addr_ldr=0, w_data_ldr=0, resp_orphan=0, stall_full=0. Reset overrides all other inputs that cycle.
- Load decode: is_load = (issue_opcode[6:4]==3'b110) || (issue_opcode[6:3]==4'b1000). Non-loads are ignored.
- Push occurs when issue_valid && is_load && !sel_stall && !full && !flush; writes issue_rd at the tail.
- Pop occurs when mem_rvalid && !empty && !flush; reads the head rd.
- On the edge after a pop: w_en_ldr=1, w_addr_ldr=head rd, w_data_ldr=mem_rdata.
- On all other edges: w_en_ldr=0; w_addr_ldr and w_data_ldr hold their last values.
- Latency: response to write enable is exactly 1 cycle.
- Simultaneous push and pop when not full: both occur; count unchanged.
- When full, push is refused even if a pop occurs the same cycle. stall_full = full (combinational from count) and stays asserted during that cycle.
- Pointers wrap modulo DEPTH. Count saturates by construction: never exceeds DEPTH and never underflows.
- Orphan response: mem_rvalid with the queue empty (including just after a flush) causes no write. resp_orphan=1 for one cycle (registered).
- Flush: on the edge, count=0 and head=tail=0. The same-cycle push and pop are discarded. w_en_ldr=0 on the next cycle.
- Flush and rst together: rst wins; the result is identical.
- pending_cnt is the registered count.

Optional Feature:
- Macro: LDR_HAZARD_EN.
- Defined: adds output ldr_hazard (1 bit, combinational).
  - High when any valid queue entry's rd equals src_a or src_b.
  - Also high when w_en_ldr=1 this cycle and w_addr_ldr equals src_a or src_b.
  - Always 0 when the queue is empty and w_en_ldr=0.
- Not defined: the port is absent; there is no comparator logic.

Test Plan:
- Reset then a single load (opcode 7'b1100000, rd=5) pushed; mem_rvalid with rdata=32'hDEADBEEF two cycles later -> the next cycle shows w_en_ldr=1, w_addr_ldr=5, w_data_ldr=32'hDEADBEEF; pending_cnt goes 1 then 0.
- Push 4 loads rd=1,2,3,4 (DEPTH=4) -> stall_full=1 and a 5th load is not accepted. Responses 0x11,0x22,0x33,0x44 -> writes (1,0x11),(2,0x22),(3,0x33),(4,0x44) in order.
- With the queue full, push and mem_rvalid in the same cycle -> push refused and count drops to 3. In steady state at count=2 with simultaneous push and pop -> count stays 2 and order is preserved across pointer wrap.
- Push 2 loads then assert flush together with mem_rvalid -> no write; pending_cnt=0. A later mem_rvalid -> resp_orphan pulses once with w_en_ldr=0.
- Non-load opcode 7'b0000000 with issue_valid, and a load issued with sel_stall=1 -> pending_cnt stays 0.
- LDR_HAZARD_EN: pending rd=7 and src_a=7 -> ldr_hazard=1. src_a=src_b=3 -> 0. After the rd=7 write completes and the queue is empty -> 0.
